armleocpu_wb_arbiter: RTL and testbench
=======================================

ARMLEOCPU_WB_ARBITER -- requirements
Module: armleocpu_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, consecutive lost cycles before port B gets priority (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports a_valid in 1, a_ready out 1, a_addr in 5, a_wdata in 32: load/memory writeback requester.
REQ-005 SHALL have ports b_valid in 1, b_ready out 1, b_addr in 5, b_wdata in 32: execute writeback requester.
REQ-006 SHALL have ports rd_addr out 5, rd_wdata out 32, rd_write out 1: drive the register file write port.
REQ-007 SHALL have ports issue_valid in 1, issue_ready out 1, issue_rd in 5: instruction issue reserving a destination.
REQ-008 SHALL have ports rs1_addr in 5, rs2_addr in 5, rs1_busy out 1, rs2_busy out 1: operand hazard query.
REQ-009 SHALL have ports rs1_fwd out 1, rs1_fwd_data out 32, rs2_fwd out 1, rs2_fwd_data out 32: bypass results.

Function
REQ-010 SHALL accept at most one writeback per cycle; a transfer occurs when valid && ready on a port.
REQ-011 SHALL grant A over B by default; ready outputs are combinational from valids and starve counter.
REQ-012 SHALL count cycles with b_valid high and b not granted; counter resets to 0 on B grant or b_valid low.
REQ-013 SHALL, when counter == STARVE_LIMIT, grant B over A for that cycle only.
REQ-014 SHALL register the granted addr/wdata into the write stage; rd_write asserts exactly 1 cycle after acceptance (latency 1).
REQ-015 SHALL force rd_write low when the accepted addr is 0; data still registered, no scoreboard effect.
REQ-016 SHALL keep a 32-bit pending bitmap; bit 0 permanently 0.
REQ-017 SHALL set pending[issue_rd] on issue_valid && issue_ready with issue_rd != 0.
REQ-018 SHALL clear pending[rd_addr] when rd_write is high.
REQ-019 SHALL let set win over clear when both target the same register in one cycle.
REQ-020 SHALL drive issue_ready = !pending[issue_rd] || issue_rd == 0 (no WAW double reservation).
REQ-021 SHALL drive rsN_busy = pending[rsN_addr], combinationally.
REQ-022 SHALL not stall either requester: write stage drains every cycle, so ready depends only on arbitration.

Reset
REQ-023 SHALL, with rst high at a clock edge, clear pending, starve counter, write stage; rd_write=0, rd_addr=0, rd_wdata=0.
REQ-024 SHALL drive a_ready=b_ready=0 and issue_ready=0 while rst is high.
REQ-025 SHALL drop any in-flight accepted write when rst asserts mid-operation; no rd_write follows reset.

Configuration
REQ-026 SHALL, with ARMLEOCPU_WB_BYPASS_EN defined, assert rsN_fwd and drive rsN_fwd_data=rd_wdata when rd_write && rd_addr==rsN_addr, and suppress rsN_busy in that case.
REQ-027 SHALL, without ARMLEOCPU_WB_BYPASS_EN, tie rsN_fwd=0 and rsN_fwd_data=0; busy follows REQ-021 only.

Structure
REQ-028 SHALL take register address width (5), data width (32), x0 index from the shared armleocpu package constants.
REQ-029 SHALL implement arbitration plus starve counter as sub-module armleocpu_wb_rr_sel; scoreboard and write stage stay in top.

Verification
REQ-030 SHALL cover: a_valid,b_valid high, a_addr=5, b_addr=6, STARVE_LIMIT=4 held -> A granted 4 cycles, B granted 5th, counter 0 after.
REQ-031 SHALL cover: issue_rd=7, then a writes x7=0xDEADBEEF -> rs1_busy(rs1=7) high until rd_write cycle, low after; rd_wdata=0xDEADBEEF.
REQ-032 SHALL cover: b writes x0=0x1234 -> rd_write stays 0, pending unchanged, b_ready was 1.
REQ-033 SHALL cover: issue_rd=9 while rd_write to x9 same cycle -> pending[9]=1 next cycle; second issue_rd=9 -> issue_ready=0.
REQ-034 SHALL cover: rst pulsed the cycle after a accepts x3 -> no rd_write for x3, all busy low, outputs 0.
REQ-035 SHALL cover with ARMLEOCPU_WB_BYPASS_EN: rd_write x4=0x55 with rs2_addr=4 -> rs2_fwd=1, rs2_fwd_data=0x55, rs2_busy=0; without macro rs2_fwd=0, rs2_busy=1.

Source files
------------

// File: rtl/armleocpu_wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter slice:
// register-file geometry, the x0 index and the starve counter width.
package armleocpu_wb_arbiter_pkg;

    localparam int unsigned ARMLEOCPU_REG_ADDR_W = 5;
    localparam int unsigned ARMLEOCPU_XLEN       = 32;
    localparam int unsigned ARMLEOCPU_REG_COUNT  = 32;
    localparam logic [ARMLEOCPU_REG_ADDR_W-1:0] ARMLEOCPU_X0 = '0;

    // Wide enough for the largest supported STARVE_LIMIT (15).
    localparam int unsigned ARMLEOCPU_STARVE_CNT_W = 4;

    typedef logic [ARMLEOCPU_REG_ADDR_W-1:0] armleocpu_reg_addr_t;
    typedef logic [ARMLEOCPU_XLEN-1:0]       armleocpu_xlen_t;

    // x0 is hardwired to zero: writes to it are discarded, it is never busy.
    function automatic logic armleocpu_is_x0(input armleocpu_reg_addr_t addr);
        return addr == ARMLEOCPU_X0;
    endfunction

endpackage

// File: rtl/armleocpu_wb_arbiter_rr_sel.sv
// Two-requester writeback selector with anti-starvation.
// A wins by default; once B has lost STARVE_LIMIT consecutive cycles it wins
// exactly one cycle. Grants are combinational and forced low during reset.
module armleocpu_wb_rr_sel
    import armleocpu_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_grant,
    output logic b_grant
);

    localparam logic [ARMLEOCPU_STARVE_CNT_W-1:0] LIMIT_C =
        ARMLEOCPU_STARVE_CNT_W'(STARVE_LIMIT);

    logic [ARMLEOCPU_STARVE_CNT_W-1:0] starve_cnt_q;
    logic [ARMLEOCPU_STARVE_CNT_W-1:0] starve_cnt_d;
    logic                              b_priority;

    // Grant decision and next starve count
    always_comb begin
        b_priority = (starve_cnt_q == LIMIT_C);
        b_grant    = !rst && b_valid && (!a_valid || b_priority);
        a_grant    = !rst && a_valid && !(b_valid && b_priority);

        // Only consecutive losses count; a win or an idle B restarts the count.
        if (b_valid && !b_grant)
            starve_cnt_d = starve_cnt_q + 1'b1;
        else
            starve_cnt_d = '0;
    end

    // Starve counter register
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt_q <= '0;
        else
            starve_cnt_q <= starve_cnt_d;
    end

endmodule

// File: rtl/armleocpu_wb_arbiter.sv
// Register-file writeback arbiter with destination scoreboard.
// Two writeback requesters share one register-file write port through a
// one-cycle write stage; a pending bitmap tracks destinations reserved at
// issue so operand reads can detect RAW hazards.
// Optional build macro ARMLEOCPU_WB_BYPASS_EN forwards the value being written
// this cycle to matching operand queries and hides their busy flag.
module armleocpu_wb_arbiter
    import armleocpu_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            a_valid,
    output logic                            a_ready,
    input  logic [ARMLEOCPU_REG_ADDR_W-1:0] a_addr,
    input  logic [ARMLEOCPU_XLEN-1:0]       a_wdata,

    input  logic                            b_valid,
    output logic                            b_ready,
    input  logic [ARMLEOCPU_REG_ADDR_W-1:0] b_addr,
    input  logic [ARMLEOCPU_XLEN-1:0]       b_wdata,

    output logic [ARMLEOCPU_REG_ADDR_W-1:0] rd_addr,
    output logic [ARMLEOCPU_XLEN-1:0]       rd_wdata,
    output logic                            rd_write,

    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [ARMLEOCPU_REG_ADDR_W-1:0] issue_rd,

    input  logic [ARMLEOCPU_REG_ADDR_W-1:0] rs1_addr,
    input  logic [ARMLEOCPU_REG_ADDR_W-1:0] rs2_addr,
    output logic                            rs1_busy,
    output logic                            rs2_busy,

    output logic                            rs1_fwd,
    output logic [ARMLEOCPU_XLEN-1:0]       rs1_fwd_data,
    output logic                            rs2_fwd,
    output logic [ARMLEOCPU_XLEN-1:0]       rs2_fwd_data
);

    logic a_grant;
    logic b_grant;

    logic                            wr_vld_q,  wr_vld_d;
    logic [ARMLEOCPU_REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ARMLEOCPU_XLEN-1:0]       wr_data_q, wr_data_d;

    logic [ARMLEOCPU_REG_COUNT-1:0]  pending_q, pending_d;
    logic                            issue_fire;

    armleocpu_wb_rr_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_rr_sel (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_grant (a_grant),
        .b_grant (b_grant)
    );

    // The write stage drains every cycle, so ready is purely the arbitration result.
    assign a_ready = a_grant;
    assign b_ready = b_grant;

    // Capture the granted request into the write stage; x0 writes keep data but never write
    always_comb begin
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (a_grant) begin
            wr_vld_d  = !armleocpu_is_x0(a_addr);
            wr_addr_d = a_addr;
            wr_data_d = a_wdata;
        end else if (b_grant) begin
            wr_vld_d  = !armleocpu_is_x0(b_addr);
            wr_addr_d = b_addr;
            wr_data_d = b_wdata;
        end
    end

    // Register-file port; a write already in the stage is dropped while reset is high
    always_comb begin
        rd_write = wr_vld_q && !rst;
        rd_addr  = rst ? '0 : wr_addr_q;
        rd_wdata = rst ? '0 : wr_data_q;
    end

    // Scoreboard next state: retire on write, reserve on issue (reserve wins on collision)
    always_comb begin
        issue_ready = !rst && (!pending_q[issue_rd] || armleocpu_is_x0(issue_rd));
        issue_fire  = issue_valid && issue_ready && !armleocpu_is_x0(issue_rd);

        pending_d = pending_q;
        if (rd_write)
            pending_d[rd_addr] = 1'b0;
        if (issue_fire)
            pending_d[issue_rd] = 1'b1;
        pending_d[ARMLEOCPU_X0] = 1'b0;
    end

`ifdef ARMLEOCPU_WB_BYPASS_EN
    // Operand query with bypass from the value being written this cycle
    always_comb begin
        rs1_fwd      = rd_write && (rd_addr == rs1_addr);
        rs2_fwd      = rd_write && (rd_addr == rs2_addr);
        rs1_fwd_data = rs1_fwd ? rd_wdata : '0;
        rs2_fwd_data = rs2_fwd ? rd_wdata : '0;
        rs1_busy     = pending_q[rs1_addr] && !rs1_fwd;
        rs2_busy     = pending_q[rs2_addr] && !rs2_fwd;
    end
`else
    // Operand query straight from the scoreboard; no forwarding path
    always_comb begin
        rs1_fwd      = 1'b0;
        rs2_fwd      = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        rs1_busy     = pending_q[rs1_addr];
        rs2_busy     = pending_q[rs2_addr];
    end
`endif

    // Write stage and scoreboard registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_armleocpu_wb_arbiter.sv
// Scenario bench for armleocpu_wb_arbiter plus a randomized run against a
// behavioural model (loss counting, reservation set, expected write).
module tb_armleocpu_wb_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
`ifdef ARMLEOCPU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        a_valid, a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_valid, b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        rd_write;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        rs1_fwd, rs2_fwd;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;

    int checks = 0;
    int errors = 0;

    armleocpu_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_wdata(b_wdata),
        .rd_addr(rd_addr), .rd_wdata(rd_wdata), .rd_write(rd_write),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_fwd(rs1_fwd), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_addr = 0; a_wdata = 0;
        b_valid = 0; b_addr = 0; b_wdata = 0;
        issue_valid = 0; issue_rd = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; a_valid = 1; b_valid = 1; issue_valid = 1; issue_rd = 7; rs1_addr = 7;
        tick(); tick();
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got=%0b want=0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got=%0b want=0", b_ready); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready got=%0b want=0", issue_ready); end
        checks++; if (rd_write !== 1'b0) begin errors++; $display("FAIL reset_rd_write got=%0b want=0", rd_write); end
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
        checks++; if (rd_wdata !== 32'd0) begin errors++; $display("FAIL reset_rd_wdata got=%0h want=0", rd_wdata); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy got=%0b want=0", rs1_busy); end
        rst = 0; idle_inputs(); issue_rd = 7;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL post_reset_issue_ready got=%0b want=1", issue_ready); end
        tick();
    endtask

    task automatic test_starve();
        idle_inputs();
        for (int k = 0; k <= int'(STARVE_LIMIT) + 1; k++) begin
            a_valid = 1; a_addr = 5; a_wdata = 32'h1000 + k;
            b_valid = 1; b_addr = 6; b_wdata = 32'h2000 + k;
            #1;
            checks++; if (a_ready !== (k != int'(STARVE_LIMIT))) begin errors++; $display("FAIL starve_a_ready k=%0d got=%0b want=%0b", k, a_ready, k != int'(STARVE_LIMIT)); end
            checks++; if (b_ready !== (k == int'(STARVE_LIMIT))) begin errors++; $display("FAIL starve_b_ready k=%0d got=%0b want=%0b", k, b_ready, k == int'(STARVE_LIMIT)); end
            tick();
            checks++; if (rd_write !== 1'b1 || rd_addr !== ((k == int'(STARVE_LIMIT)) ? 5'd6 : 5'd5))
                begin errors++; $display("FAIL starve_rd k=%0d got=%0b/%0d want=1/%0d", k, rd_write, rd_addr, (k == int'(STARVE_LIMIT)) ? 6 : 5); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_raw();
        idle_inputs();
        issue_valid = 1; issue_rd = 7; rs1_addr = 7;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_issue_ready got=%0b want=1", issue_ready); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL raw_busy_before got=%0b want=0", rs1_busy); end
        tick();
        issue_valid = 0;
        #1;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL raw_busy_reserved got=%0b want=1", rs1_busy); end
        a_valid = 1; a_addr = 7; a_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL raw_a_ready got=%0b want=1", a_ready); end
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL raw_busy_accept got=%0b want=1", rs1_busy); end
        tick();
        a_valid = 0;
        #1;
        checks++; if (rd_write !== 1'b1 || rd_addr !== 5'd7) begin errors++; $display("FAIL raw_rd_write got=%0b/%0d want=1/7", rd_write, rd_addr); end
        checks++; if (rd_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_rd_wdata got=%0h want=deadbeef", rd_wdata); end
        checks++; if (rs1_busy !== !BYP) begin errors++; $display("FAIL raw_busy_write_cycle got=%0b want=%0b", rs1_busy, !BYP); end
        tick();
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL raw_busy_after got=%0b want=0", rs1_busy); end
        checks++; if (rd_write !== 1'b0) begin errors++; $display("FAIL raw_rd_write_after got=%0b want=0", rd_write); end
    endtask

    task automatic test_x0_write();
        idle_inputs();
        issue_valid = 1; issue_rd = 12;
        tick();
        issue_valid = 0; rs1_addr = 0; rs2_addr = 12;
        b_valid = 1; b_addr = 0; b_wdata = 32'h1234;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL x0_b_ready got=%0b want=1", b_ready); end
        tick();
        b_valid = 0;
        #1;
        checks++; if (rd_write !== 1'b0) begin errors++; $display("FAIL x0_rd_write got=%0b want=0", rd_write); end
        checks++; if (rd_wdata !== 32'h1234) begin errors++; $display("FAIL x0_rd_wdata got=%0h want=1234", rd_wdata); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got=%0b want=0", rs1_busy); end
        tick();
        checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL x0_pending_kept got=%0b want=1", rs2_busy); end
        a_valid = 1; a_addr = 12; a_wdata = 32'hC;
        tick();
        a_valid = 0;
        tick();
        checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL x0_cleanup_busy got=%0b want=0", rs2_busy); end
    endtask

    task automatic test_set_wins();
        idle_inputs();
        a_valid = 1; a_addr = 9; a_wdata = $urandom;
        tick();
        a_valid = 0; issue_valid = 1; issue_rd = 9; rs1_addr = 9;
        #1;
        checks++; if (rd_write !== 1'b1 || rd_addr !== 5'd9) begin errors++; $display("FAIL setwin_rd got=%0b/%0d want=1/9", rd_write, rd_addr); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL setwin_first_issue got=%0b want=1", issue_ready); end
        tick();
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL setwin_second_issue got=%0b want=0", issue_ready); end
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL setwin_pending got=%0b want=1", rs1_busy); end
        issue_valid = 0;
        a_valid = 1; a_addr = 9;
        tick();
        a_valid = 0;
        tick();
    endtask

    task automatic test_bypass();
        idle_inputs();
        issue_valid = 1; issue_rd = 4; rs2_addr = 4;
        tick();
        issue_valid = 0; a_valid = 1; a_addr = 4; a_wdata = 32'h55;
        tick();
        a_valid = 0;
        #1;
        checks++; if (rd_write !== 1'b1) begin errors++; $display("FAIL byp_rd_write got=%0b want=1", rd_write); end
        checks++; if (rs2_fwd !== BYP) begin errors++; $display("FAIL byp_rs2_fwd got=%0b want=%0b", rs2_fwd, BYP); end
        checks++; if (rs2_fwd_data !== (BYP ? 32'h55 : 32'h0)) begin errors++; $display("FAIL byp_rs2_fwd_data got=%0h want=%0h", rs2_fwd_data, BYP ? 32'h55 : 32'h0); end
        checks++; if (rs2_busy !== !BYP) begin errors++; $display("FAIL byp_rs2_busy got=%0b want=%0b", rs2_busy, !BYP); end
        tick();
    endtask

    task automatic test_reset_midflight();
        idle_inputs();
        issue_valid = 1; issue_rd = 3; rs1_addr = 3;
        tick();
        issue_valid = 0; a_valid = 1; a_addr = 3; a_wdata = 32'hA5A5;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL midrst_accept got=%0b want=1", a_ready); end
        tick();
        rst = 1;
        #1;
        checks++; if (rd_write !== 1'b0) begin errors++; $display("FAIL midrst_rd_write got=%0b want=0", rd_write); end
        checks++; if (rd_addr !== 5'd0 || rd_wdata !== 32'd0) begin errors++; $display("FAIL midrst_rd_out got=%0d/%0h want=0/0", rd_addr, rd_wdata); end
        checks++; if (a_ready !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%0b/%0b want=0/0", a_ready, issue_ready); end
        tick();
        rst = 0; a_valid = 0; rs2_addr = 7;
        #1;
        checks++; if (rd_write !== 1'b0 || rd_addr !== 5'd0 || rd_wdata !== 32'd0) begin errors++; $display("FAIL midrst_after got=%0b/%0d/%0h want=0/0/0", rd_write, rd_addr, rd_wdata); end
        checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b/%0b want=0/0", rs1_busy, rs2_busy); end
        tick();
        checks++; if (rd_write !== 1'b0) begin errors++; $display("FAIL midrst_late_write got=%0b want=0", rd_write); end
    endtask

    task automatic test_random();
        bit [31:0] m_pend;
        int        m_lost;
        bit        m_wr, m_xfer;
        bit [4:0]  m_addr;
        bit [31:0] m_data;
        bit e_bwin, e_ar, e_br, e_rdw, e_ir, e_f1, e_f2, e_b1, e_b2;
        bit [4:0]  e_rda;
        bit [31:0] e_rdd;

        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        m_pend = '0; m_lost = 0; m_wr = 0; m_xfer = 0; m_addr = 0; m_data = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            rst         = ($urandom_range(0, 39) == 0);
            a_valid     = ($urandom_range(0, 3) != 0);
            b_valid     = ($urandom_range(0, 3) != 0);
            a_addr      = 5'($urandom_range(0, 7));
            b_addr      = 5'($urandom_range(0, 7));
            a_wdata     = $urandom;
            b_wdata     = $urandom;
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            #1;
            e_bwin = b_valid && (!a_valid || m_lost == int'(STARVE_LIMIT));
            e_ar   = !rst && a_valid && !e_bwin;
            e_br   = !rst && e_bwin;
            e_rdw  = !rst && m_wr;
            e_rda  = rst ? 5'd0 : m_addr;
            e_rdd  = rst ? 32'd0 : m_data;
            e_ir   = !rst && (issue_rd == 0 || !m_pend[issue_rd]);
            e_f1   = BYP && e_rdw && (m_addr == rs1_addr);
            e_f2   = BYP && e_rdw && (m_addr == rs2_addr);
            e_b1   = m_pend[rs1_addr] && !e_f1;
            e_b2   = m_pend[rs2_addr] && !e_f2;

            checks++; if (a_ready !== e_ar || b_ready !== e_br) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%0b%0b want=%0b%0b", cyc, a_ready, b_ready, e_ar, e_br); end
            checks++; if (rd_write !== e_rdw) begin errors++; $display("FAIL rnd_rd_write cyc=%0d got=%0b want=%0b", cyc, rd_write, e_rdw); end
            if (e_rdw || rst || m_xfer) begin
                checks++; if (rd_addr !== e_rda || rd_wdata !== e_rdd) begin errors++; $display("FAIL rnd_rd_data cyc=%0d got=%0d/%0h want=%0d/%0h", cyc, rd_addr, rd_wdata, e_rda, e_rdd); end
            end
            checks++; if (issue_ready !== e_ir) begin errors++; $display("FAIL rnd_issue_ready cyc=%0d got=%0b want=%0b", cyc, issue_ready, e_ir); end
            checks++; if (rs1_busy !== e_b1 || rs2_busy !== e_b2) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%0b%0b want=%0b%0b", cyc, rs1_busy, rs2_busy, e_b1, e_b2); end
            checks++; if (rs1_fwd !== e_f1 || rs2_fwd !== e_f2) begin errors++; $display("FAIL rnd_fwd cyc=%0d got=%0b%0b want=%0b%0b", cyc, rs1_fwd, rs2_fwd, e_f1, e_f2); end
            checks++; if (rs1_fwd_data !== (e_f1 ? e_rdd : 32'd0) || rs2_fwd_data !== (e_f2 ? e_rdd : 32'd0))
                begin errors++; $display("FAIL rnd_fwd_data cyc=%0d got=%0h/%0h", cyc, rs1_fwd_data, rs2_fwd_data); end

            @(posedge clk);
            if (rst) begin
                m_pend = '0; m_lost = 0; m_wr = 0; m_xfer = 0; m_addr = 0; m_data = 0;
            end else begin
                if (e_rdw) m_pend[m_addr] = 1'b0;
                if (issue_valid && e_ir && issue_rd != 0) m_pend[issue_rd] = 1'b1;
                m_lost = (b_valid && !e_br) ? m_lost + 1 : 0;
                if (e_ar) begin
                    m_xfer = 1; m_wr = (a_addr != 0); m_addr = a_addr; m_data = a_wdata;
                end else if (e_br) begin
                    m_xfer = 1; m_wr = (b_addr != 0); m_addr = b_addr; m_data = b_wdata;
                end else begin
                    m_xfer = 0; m_wr = 0;
                end
            end
            #1;
        end
        idle_inputs();
        rst = 0;
        tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        tick();
        test_reset();
        test_starve();
        test_raw();
        test_x0_write();
        test_set_wins();
        test_bypass();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
